// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, drives the instruction SRAM req/ack port, holds fetched words for decode.
// Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned PC_STEP     = 4,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        fetch_err
);

    localparam int unsigned PC_W   = 32;
    localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DELIVER = 2'd2,
        ERROR   = 2'd3
    } state_e;

    // Elaboration-time sanity check on configuration.
    if (RESET_PC[1:0] != 2'b00 || TIMEOUT_CYC == 0) begin : g_bad_cfg
        $error("fetch_ctrl: RESET_PC must be word aligned and TIMEOUT_CYC nonzero");
    end

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [31:0]       inst_q, inst_d;
    logic [PC_W-1:0]   inst_pc_q, inst_pc_d;
    logic              inst_valid_q, inst_valid_d;
    logic              fetch_err_q, fetch_err_d;
    logic              bubble_q, bubble_d;
`ifdef FETCH_TIMEOUT_EN
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
`endif

    // Request is suppressed for the one-cycle bubble that follows an accepted redirect.
    assign mem_req    = (state_q == FETCH) && !bubble_q;
    assign mem_addr   = mem_req ? pc_q : '0;
    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign fetch_err  = fetch_err_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
        fetch_err_d  = fetch_err_q;
        bubble_d     = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        tcnt_d       = tcnt_q;
`endif

        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (mem_req && mem_ack) begin
                    inst_d       = mem_rdata;
                    inst_pc_d    = pc_q;
                    inst_valid_d = 1'b1;
                    pc_d         = pc_q + PC_W'(PC_STEP);
                    state_d      = DELIVER;
`ifdef FETCH_TIMEOUT_EN
                end else if (mem_req) begin
                    if (tcnt_q == TCNT_W'(TIMEOUT_CYC - 1)) begin
                        fetch_err_d = 1'b1;
                        state_d     = ERROR;
                    end else begin
                        tcnt_d = tcnt_q + TCNT_W'(1);
                    end
`endif
                end
            end
            DELIVER: begin
                if (!stall) begin
                    inst_valid_d = 1'b0;
                    state_d      = FETCH;
                end
            end
            default: begin
                inst_valid_d = 1'b0;
                fetch_err_d  = 1'b1;
            end
        endcase

        // Redirect overrides ack and stall everywhere except the terminal error state.
        if (redirect_valid && state_q != ERROR) begin
            inst_valid_d = 1'b0;
            if (redirect_pc[1:0] == 2'b00) begin
                pc_d     = redirect_pc;
                state_d  = FETCH;
                bubble_d = 1'b1;
            end else begin
                fetch_err_d = 1'b1;
                state_d     = ERROR;
            end
        end

`ifdef FETCH_TIMEOUT_EN
        if ((state_d == FETCH && state_q != FETCH) || (redirect_valid && state_q != ERROR)) begin
            tcnt_d = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_valid_q <= 1'b0;
            fetch_err_q  <= 1'b0;
            bubble_q     <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            tcnt_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
            fetch_err_q  <= fetch_err_d;
            bubble_q     <= bubble_d;
`ifdef FETCH_TIMEOUT_EN
            tcnt_q       <= tcnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: sequential fetch, stall hold, redirect, misaligned error, PC wrap, timeout/reset.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        fetch_err;

    int n_checks = 0;
    int n_errors = 0;

    fetch_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .fetch_err      (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM stand-in: word tagged with the low half of its address.
    assign mem_rdata = {16'hC0DE, mem_addr[15:0]};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   32'(mem_req),    32'h0);
        check({tag, "_addr"},  mem_addr,        32'h0);
        check({tag, "_valid"}, 32'(inst_valid), 32'h0);
        check({tag, "_inst"},  inst,            32'h0);
        check({tag, "_pc"},    inst_pc,         32'h0);
        check({tag, "_err"},   32'(fetch_err),  32'h0);
    endtask

    initial begin
        rst_n          = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        mem_ack        = 1'b0;
        repeat (2) tick();
        check_reset_outputs("rst");

        // Sequential fetch, ack every FETCH cycle, no stall
        rst_n = 1'b1;
        tick();
        check("t1_req0",  32'(mem_req), 32'h1);
        check("t1_addr0", mem_addr,     32'h0);
        mem_ack = 1'b1;
        tick();
        check("t1_valid0", 32'(inst_valid), 32'h1);
        check("t1_ipc0",   inst_pc,         32'h0);
        check("t1_inst0",  inst,            32'hC0DE_0000);
        check("t1_req_dl", 32'(mem_req),    32'h0);
        tick();
        check("t1_addr4",   mem_addr,        32'h4);
        check("t1_valid_f", 32'(inst_valid), 32'h0);
        tick();
        check("t1_ipc4", inst_pc, 32'h4);
        tick();
        check("t1_addr8", mem_addr, 32'h8);

        // Stall holds the delivered word at PC 8
        stall = 1'b1;
        tick();
        check("t2_ipc8", inst_pc, 32'h8);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_hold_valid", 32'(inst_valid), 32'h1);
            check("t2_hold_pc",    inst_pc,         32'h8);
            check("t2_hold_inst",  inst,            32'hC0DE_0008);
            check("t2_hold_req",   32'(mem_req),    32'h0);
        end
        stall = 1'b0;
        tick();
        check("t2_addr12", mem_addr, 32'hC);

        // Redirect same cycle as ack at PC 12
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick();
        redirect_valid = 1'b0;
        check("t3_valid_drop", 32'(inst_valid), 32'h0);
        check("t3_req_bubble", 32'(mem_req),    32'h0);
        tick();
        check("t3_addr40", mem_addr, 32'h40);
        tick();
        check("t3_valid40", 32'(inst_valid), 32'h1);
        check("t3_ipc40",   inst_pc,         32'h40);
        check("t3_inst40",  inst,            32'hC0DE_0040);

        // Misaligned redirect -> sticky error, later redirect ignored
        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        tick();
        check("t4_err",   32'(fetch_err),  32'h1);
        check("t4_valid", 32'(inst_valid), 32'h0);
        check("t4_req",   32'(mem_req),    32'h0);
        redirect_pc = 32'h80;
        tick();
        redirect_valid = 1'b0;
        tick();
        check("t4_req_after", 32'(mem_req),   32'h0);
        check("t4_addr",      mem_addr,       32'h0);
        check("t4_err_stick", 32'(fetch_err), 32'h1);

        // Async reset clears the error without a clock edge
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t4_rst");
        tick();
        rst_n = 1'b1;
        tick();
        check("t5_addr0", mem_addr, 32'h0);

        // Redirect to top word, PC wraps to zero
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        check("t5_bubble", 32'(mem_req), 32'h0);
        tick();
        check("t5_addr_top", mem_addr, 32'hFFFF_FFFC);
        tick();
        check("t5_ipc_top",  inst_pc, 32'hFFFF_FFFC);
        check("t5_inst_top", inst,    32'hC0DE_FFFC);
        tick();
        check("t5_wrap_addr", mem_addr,     32'h0);
        check("t5_wrap_req",  32'(mem_req), 32'h1);

        // No ack: watchdog fires after 16 FETCH cycles, or waits forever when disabled
        mem_ack = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        repeat (15) tick();
        check("t6_err_pre", 32'(fetch_err), 32'h0);
        check("t6_req_pre", 32'(mem_req),   32'h1);
        tick();
        check("t6_err",     32'(fetch_err), 32'h1);
        check("t6_req_off", 32'(mem_req),   32'h0);
`else
        repeat (40) tick();
        check("t6_req_wait", 32'(mem_req),   32'h1);
        check("t6_err_none", 32'(fetch_err), 32'h0);
        check("t6_addr",     mem_addr,       32'h0);
`endif
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_rst");
        tick();
        rst_n = 1'b1;
        tick();
        check("t6_restart_req",  32'(mem_req), 32'h1);
        check("t6_restart_addr", mem_addr,     32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
